hpdmc_ddr_wrpath: RTL and testbench
===================================

// Module: hpdmc_ddr_wrpath
// PURPOSE
//  Parametrised DDR write-path sequencer for the HPDMC SDRAM controller, in the sys_clk domain.
//  Accepts a write-start strobe plus burst data from the datapath.
//  Produces the per-cycle rising/falling (D0/D1) data, mask and DQS patterns for the external ODDR2 stage.
//  Also produces the DQ/DQS tristate enables, including DQS preamble and postamble.
//  Generalises the fixed 2-bit ODDR pair to any DQ width, burst length and write latency.
//  Adds handshaking and error reporting.
// PARAMETERS
//  DQ_WIDTH       16  SDRAM DQ pins; multiple of 8; NL = DQ_WIDTH/8 byte lanes
//  BURST_LEN      4   DDR beats per burst; even, >=2; NB = BURST_LEN/2 sys_clk data cycles
//  WRITE_LATENCY  1   cycles from wr_start sample to the preamble cycle; >=1
// PORTS
//  sys_clk    in   1            system clock; all logic on its rising edge
//  sys_rst    in   1            asynchronous, active-high reset
//  wr_start   in   1            write command issued; accepted only when wr_ready=1
//  wr_ready   out  1            1 when in IDLE (combinational from state)
//  din        in   2*DQ_WIDTH   beat pair: [DQ_WIDTH-1:0]=rising beat, upper half=falling beat
//  din_mask   in   2*NL         byte masks: [NL-1:0]=rising beat, upper half=falling beat; 1=masked
//  din_valid  in   1            din/din_mask valid
//  din_ready  out  1            beat pair consumed this cycle (din_valid ignored when 0)
//  dq_d0      out  DQ_WIDTH     ODDR D0 (rising) data
//  dq_d1      out  DQ_WIDTH     ODDR D1 (falling) data
//  dm_d0      out  NL           ODDR D0 mask
//  dm_d1      out  NL           ODDR D1 mask
//  dq_oe      out  1            DQ/DM output enable
//  dqs_d0     out  NL           DQS ODDR D0
//  dqs_d1     out  NL           DQS ODDR D1
//  dqs_oe     out  1            DQS output enable
//  err_clr    in   1            clears the sticky error flags
//  err_busy   out  1            sticky: wr_start seen while wr_ready=0
//  err_under  out  1            sticky: din_valid=0 when din_ready=1
// BEHAVIOUR
//  Reset (async, immediate, also mid-burst):
//   - state=IDLE; dq_d0/dq_d1=0; dm_d0/dm_d1=all 1; dqs_d0/dqs_d1=0; dq_oe=0; dqs_oe=0.
//   - Error flags cleared; beat and latency counters cleared.
//  FSM: IDLE -> WAIT (WRITE_LATENCY-1 cycles; skipped if WRITE_LATENCY=1) -> PRE (1 cycle) -> BURST (NB cycles) -> POST (1 cycle) -> IDLE.
//   - wr_start sampled at the end of cycle T -> PRE during cycle T+L (L=WRITE_LATENCY).
//   - BURST occupies T+L+1 .. T+L+NB; POST occupies T+L+NB+1.
//  All data-side outputs are registered; the output values per state are:
//   - IDLE/WAIT: dq_oe=0, dqs_oe=0, dqs=0/0, dm=all 1, dq=0.
//   - PRE: dqs_oe=1, dqs_d0=dqs_d1=0, dq_oe=0.
//   - BURST: dqs_oe=1, dqs_d0=all 1, dqs_d1=0, dq_oe=1; dq/dm hold the pair sampled in the previous cycle.
//   - POST: dqs_oe=1, dqs=0/0, dq_oe=0, dm=all 1.
//  din_ready=1 in cycles T+L .. T+L+NB-1 (PRE and all BURST cycles but the last), which is exactly NB pulses.
//   - Each pulse samples din/din_mask at the end of that cycle for output in the next cycle.
//  Underrun: if din_ready=1 and din_valid=0:
//   - the pair is replaced by dq=0, dm=all 1;
//   - err_under is set; the burst still completes on schedule (no stall).
//  wr_start while not IDLE: ignored and err_busy set; the sequence in progress is undisturbed.
//   - Back-to-back bursts therefore need wr_start in the IDLE cycle after POST.
//  err_clr: clears both flags at the next edge.
//   - A new error in the same cycle wins (the flag stays set).
//  Beat counter: width clog2(NB)+1, restarts at 0 on entering PRE, never wraps within a burst.
// TESTING
//  - Reset: assert sys_rst mid-BURST -> dq_oe=dqs_oe=0, dm=all 1, wr_ready=1 without waiting for a clock edge.
//  - DQ16/BL4/L1: wr_start at T, din pairs 0xA5A5_5A5A, 0x1234_5678 valid:
//    - din_ready at T+1 and T+2;
//    - PRE at T+1; dq_d0=0x5A5A, dq_d1=0xA5A5 at T+2; dq_d0=0x5678, dq_d1=0x1234 at T+3;
//    - POST at T+4; IDLE at T+5.
//  - L=3, BL8: PRE at T+3; four BURST cycles T+4..T+7 with dqs_d0=2'b11, dqs_d1=0; POST at T+8.
//  - Underrun: din_valid=0 on the 2nd din_ready -> that beat has dm=all 1, dq=0; err_under=1; burst length unchanged.
//  - wr_start during BURST -> err_busy=1, output sequence identical to the undisturbed case.
//    - err_clr pulse -> both flags 0 next cycle.
//  - Back-to-back: wr_start in the first IDLE after POST -> second PRE L cycles later, no glitch on dqs_oe.

Source files
------------

// File: rtl/hpdmc_ddr_wrpath.sv
// DDR write-path sequencer: turns a write-start strobe plus beat-pair data into
// per-cycle ODDR D0/D1 data, mask and DQS patterns with preamble/postamble and tristate enables.
module hpdmc_ddr_wrpath #(
    parameter int DQ_WIDTH      = 16,
    parameter int BURST_LEN     = 4,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      wr_start,
    output logic                      wr_ready,
    input  logic [2*DQ_WIDTH-1:0]     din,
    input  logic [2*(DQ_WIDTH/8)-1:0] din_mask,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic [DQ_WIDTH-1:0]       dq_d0,
    output logic [DQ_WIDTH-1:0]       dq_d1,
    output logic [DQ_WIDTH/8-1:0]     dm_d0,
    output logic [DQ_WIDTH/8-1:0]     dm_d1,
    output logic                      dq_oe,
    output logic [DQ_WIDTH/8-1:0]     dqs_d0,
    output logic [DQ_WIDTH/8-1:0]     dqs_d1,
    output logic                      dqs_oe,
    input  logic                      err_clr,
    output logic                      err_busy,
    output logic                      err_under
);
    localparam int NL = DQ_WIDTH / 8;
    localparam int NB = BURST_LEN / 2;
    localparam int BW = $clog2(NB) + 1;
    localparam int LW = $clog2(WRITE_LATENCY) + 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(NB);
    localparam logic [LW-1:0] LAT_LAST  = LW'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_BURST, S_POST} state_t;

    state_t          state, state_nx;
    logic [BW-1:0]   beat, beat_nx;
    logic [LW-1:0]   lat, lat_nx;
    logic [DQ_WIDTH-1:0] dq_d0_nx, dq_d1_nx;
    logic [NL-1:0]   dm_d0_nx, dm_d1_nx;

    assign wr_ready  = (state == S_IDLE);
    // A beat pair is taken in PRE and every BURST cycle except the last, so each
    // BURST cycle shows the pair captured one cycle earlier.
    assign din_ready = (state == S_PRE) || (state == S_BURST && beat != BEAT_LAST);
    assign dqs_d1    = '0;

    // NOTE: every variable driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        beat_nx  = beat;
        lat_nx   = lat;
        case (state)
            S_IDLE: begin
                beat_nx = '0;
                if (wr_start) begin
                    if (WRITE_LATENCY == 1) begin
                        state_nx = S_PRE;
                    end else begin
                        state_nx = S_WAIT;
                        lat_nx   = LW'(1);
                    end
                end
            end
            S_WAIT: begin
                beat_nx = '0;
                if (lat == LAT_LAST) state_nx = S_PRE;
                else                 lat_nx   = lat + LW'(1);
            end
            S_PRE: begin
                state_nx = S_BURST;
                beat_nx  = beat + BW'(1);
            end
            S_BURST: begin
                if (beat == BEAT_LAST) state_nx = S_POST;
                else                   beat_nx  = beat + BW'(1);
            end
            S_POST:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        dq_d0_nx = '0;
        dq_d1_nx = '0;
        dm_d0_nx = '1;
        dm_d1_nx = '1;
        if (din_ready && din_valid) begin
            dq_d0_nx = din[DQ_WIDTH-1:0];
            dq_d1_nx = din[2*DQ_WIDTH-1:DQ_WIDTH];
            dm_d0_nx = din_mask[NL-1:0];
            dm_d1_nx = din_mask[2*NL-1:NL];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            beat      <= '0;
            lat       <= '0;
            dq_d0     <= '0;
            dq_d1     <= '0;
            dm_d0     <= '1;
            dm_d1     <= '1;
            dq_oe     <= 1'b0;
            dqs_d0    <= '0;
            dqs_oe    <= 1'b0;
            err_busy  <= 1'b0;
            err_under <= 1'b0;
        end else begin
            state     <= state_nx;
            beat      <= beat_nx;
            lat       <= lat_nx;
            dq_d0     <= dq_d0_nx;
            dq_d1     <= dq_d1_nx;
            dm_d0     <= dm_d0_nx;
            dm_d1     <= dm_d1_nx;
            // Outputs follow the state being entered so they line up with it.
            dq_oe     <= (state_nx == S_BURST);
            dqs_d0    <= {NL{state_nx == S_BURST}};
            dqs_oe    <= (state_nx == S_PRE) || (state_nx == S_BURST) || (state_nx == S_POST);
            // A new error outranks a simultaneous clear.
            err_busy  <= (wr_start && !wr_ready) || (err_busy && !err_clr);
            err_under <= (din_ready && !din_valid) || (err_under && !err_clr);
        end
    end
endmodule

// File: tb/tb_hpdmc_ddr_wrpath.sv
// Bench for hpdmc_ddr_wrpath: DQ16/BL4/L1 and DQ16/BL8/L3 instances checked
// every cycle against a cycle-offset timeline model of the write sequence.
module tb_hpdmc_ddr_wrpath;
    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    logic [1:0]       wr_start, wr_ready, din_ready, dq_oe, dqs_oe, err_busy, err_under;
    logic [31:0]      din;
    logic [3:0]       din_mask;
    logic             din_valid, err_clr;
    logic [1:0][15:0] dq_d0, dq_d1;
    logic [1:0][1:0]  dm_d0, dm_d1, dqs_d0, dqs_d1;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] pairs [4];
    logic [3:0]  pmask [4];
    bit          pvalid[4];
    bit          exp_busy [2];
    bit          exp_under[2];

    hpdmc_ddr_wrpath #(.DQ_WIDTH(16), .BURST_LEN(4), .WRITE_LATENCY(1)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_start(wr_start[0]), .wr_ready(wr_ready[0]),
        .din(din), .din_mask(din_mask), .din_valid(din_valid), .din_ready(din_ready[0]),
        .dq_d0(dq_d0[0]), .dq_d1(dq_d1[0]), .dm_d0(dm_d0[0]), .dm_d1(dm_d1[0]), .dq_oe(dq_oe[0]),
        .dqs_d0(dqs_d0[0]), .dqs_d1(dqs_d1[0]), .dqs_oe(dqs_oe[0]),
        .err_clr(err_clr), .err_busy(err_busy[0]), .err_under(err_under[0])
    );

    hpdmc_ddr_wrpath #(.DQ_WIDTH(16), .BURST_LEN(8), .WRITE_LATENCY(3)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_start(wr_start[1]), .wr_ready(wr_ready[1]),
        .din(din), .din_mask(din_mask), .din_valid(din_valid), .din_ready(din_ready[1]),
        .dq_d0(dq_d0[1]), .dq_d1(dq_d1[1]), .dm_d0(dm_d0[1]), .dm_d1(dm_d1[1]), .dq_oe(dq_oe[1]),
        .dqs_d0(dqs_d0[1]), .dqs_d1(dqs_d1[1]), .dqs_oe(dqs_oe[1]),
        .err_clr(err_clr), .err_busy(err_busy[1]), .err_under(err_under[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input int sel, input string tag, input logic e_wr_ready,
                               input logic e_din_ready, input logic e_dq_oe, input logic e_dqs_oe,
                               input logic [1:0] e_dqs0, input logic [15:0] e_dq0,
                               input logic [15:0] e_dq1, input logic [1:0] e_dm0,
                               input logic [1:0] e_dm1);
        check({tag, " wr_ready"},  wr_ready[sel],  e_wr_ready);
        check({tag, " din_ready"}, din_ready[sel], e_din_ready);
        check({tag, " dq_oe"},     dq_oe[sel],     e_dq_oe);
        check({tag, " dqs_oe"},    dqs_oe[sel],    e_dqs_oe);
        check({tag, " dqs_d0"},    dqs_d0[sel],    e_dqs0);
        check({tag, " dqs_d1"},    dqs_d1[sel],    2'b00);
        check({tag, " dq_d0"},     dq_d0[sel],     e_dq0);
        check({tag, " dq_d1"},     dq_d1[sel],     e_dq1);
        check({tag, " dm_d0"},     dm_d0[sel],     e_dm0);
        check({tag, " dm_d1"},     dm_d1[sel],     e_dm1);
    endtask

    task automatic check_flags(input int sel, input string tag);
        check({tag, " err_busy"},  err_busy[sel],  exp_busy[sel]);
        check({tag, " err_under"}, err_under[sel], exp_under[sel]);
    endtask

    // Flags set one edge after their event; a clear applies unless an event wins.
    task automatic update_flags(input int sel, input bit busy_evt, input bit under_evt);
        for (int s = 0; s < 2; s++) begin
            if (s == sel && busy_evt)  exp_busy[s] = 1'b1;
            else if (err_clr)          exp_busy[s] = 1'b0;
            if (s == sel && under_evt) exp_under[s] = 1'b1;
            else if (err_clr)          exp_under[s] = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n, input bit clr_first);
        for (int i = 0; i < n; i++) begin
            wr_start  = '0;
            din       = $urandom;
            din_mask  = 4'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            err_clr   = clr_first && (i == 0);
            #1;
            for (int s = 0; s < 2; s++) begin
                check_state(s, $sformatf("idle%0d", s), 1, 0, 0, 0, 2'b00, 16'h0, 16'h0, 2'b11, 2'b11);
                check_flags(s, $sformatf("idle%0d", s));
            end
            update_flags(-1, 0, 0);
            @(posedge sys_clk); #1;
        end
        err_clr = 1'b0;
    endtask

    // Cycle 0 holds wr_start; PRE at lat, BURST lat+1..lat+nb, POST lat+nb+1.
    task automatic run_burst(input int sel, input bit fixed, input int busy_at,
                             input int clr_at, input int rst_at);
        int lat, nb;
        lat = (sel == 1) ? 3 : 1;
        nb  = (sel == 1) ? 4 : 2;
        if (!fixed) begin
            for (int i = 0; i < nb; i++) begin
                pairs[i] = $urandom;
                pmask[i] = 4'($urandom);
            end
        end
        for (int c = 0; c <= lat + nb + 1; c++) begin
            bit e_rdy, e_burst, busy_evt, under_evt;
            int k;
            string tag;
            logic [15:0] e_dq0, e_dq1;
            logic [1:0]  e_dm0, e_dm1;
            e_rdy     = (c >= lat) && (c <= lat + nb - 1);
            e_burst   = (c >= lat + 1) && (c <= lat + nb);
            k         = e_burst ? c - lat - 1 : 0;
            busy_evt  = (c == busy_at);
            under_evt = e_rdy && !pvalid[e_rdy ? c - lat : 0];
            e_dq0 = 16'h0; e_dq1 = 16'h0; e_dm0 = 2'b11; e_dm1 = 2'b11;
            if (e_burst && pvalid[k]) begin
                e_dq0 = pairs[k][15:0];
                e_dq1 = pairs[k][31:16];
                e_dm0 = pmask[k][1:0];
                e_dm1 = pmask[k][3:2];
            end
            wr_start      = '0;
            wr_start[sel] = (c == 0) || busy_evt;
            din       = $urandom;
            din_mask  = 4'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            if (e_rdy) begin
                din       = pairs[c - lat];
                din_mask  = pmask[c - lat];
                din_valid = pvalid[c - lat];
            end
            err_clr = (c == clr_at);
            #1;
            tag = $sformatf("b%0d c%0d", sel, c);
            check_state(sel, tag, c == 0, e_rdy, e_burst, (c >= lat) && (c <= lat + nb + 1),
                        e_burst ? 2'b11 : 2'b00, e_dq0, e_dq1, e_dm0, e_dm1);
            check_flags(sel, tag);
            if (c == rst_at) begin
                sys_rst = 1'b1;
                #1;
                check_state(sel, {tag, " rst"}, 1, 0, 0, 0, 2'b00, 16'h0, 16'h0, 2'b11, 2'b11);
                check({tag, " rst err_busy"}, err_busy[sel], 1'b0);
                check({tag, " rst err_under"}, err_under[sel], 1'b0);
                sys_rst   = 1'b0;
                wr_start  = '0;
                err_clr   = 1'b0;
                exp_busy  = '{0, 0};
                exp_under = '{0, 0};
                @(posedge sys_clk); #1;
                return;
            end
            update_flags(sel, busy_evt, under_evt);
            @(posedge sys_clk); #1;
        end
        wr_start = '0;
        err_clr  = 1'b0;
    endtask

    initial begin
        sys_rst   = 1'b1;
        wr_start  = '0;
        din       = '0;
        din_mask  = '0;
        din_valid = 1'b0;
        err_clr   = 1'b0;
        exp_busy  = '{0, 0};
        exp_under = '{0, 0};
        #3;
        for (int s = 0; s < 2; s++) begin
            check_state(s, $sformatf("reset%0d", s), 1, 0, 0, 0, 2'b00, 16'h0, 16'h0, 2'b11, 2'b11);
            check_flags(s, $sformatf("reset%0d", s));
        end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        idle_cycles(2, 0);

        // Directed DQ16/BL4/L1 burst, then a back-to-back random one.
        pairs[0] = 32'hA5A5_5A5A; pairs[1] = 32'h1234_5678;
        pmask[0] = 4'h0;          pmask[1] = 4'h9;
        pvalid   = '{1, 1, 1, 1};
        run_burst(0, 1, -1, -1, -1);
        run_burst(0, 0, -1, -1, -1);

        // Underrun on the second pulse; flag must stick until cleared.
        pvalid = '{1, 0, 1, 1};
        run_burst(0, 0, -1, -1, -1);
        idle_cycles(2, 0);
        idle_cycles(2, 1);

        // wr_start during BURST: ignored, err_busy set.
        pvalid = '{1, 1, 1, 1};
        run_burst(0, 0, 2, -1, -1);
        // Clear coinciding with a new underrun: underrun stays, busy clears.
        pvalid = '{1, 0, 1, 1};
        run_burst(0, 0, -1, 2, -1);
        idle_cycles(1, 1);

        // BL8/L3 instance: clean, back-to-back with underrun and busy poke.
        pvalid = '{1, 1, 1, 1};
        run_burst(1, 0, -1, -1, -1);
        pvalid = '{1, 1, 0, 1};
        run_burst(1, 0, 5, -1, -1);
        idle_cycles(1, 1);

        // Asynchronous reset in the middle of a BURST.
        pvalid = '{1, 1, 1, 1};
        run_burst(1, 0, -1, -1, 5);
        idle_cycles(1, 0);

        for (int r = 0; r < 8; r++) begin
            int sel;
            sel = $urandom_range(0, 1);
            for (int i = 0; i < 4; i++) pvalid[i] = ($urandom_range(0, 3) != 0);
            run_burst(sel, 0, -1, -1, -1);
            idle_cycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        idle_cycles(1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
